// File: rtl/rv32m_pkg.sv
// rtl/rv32m_pkg.sv - shared encodings and constants for the RV32M divide unit
package rv32m_pkg;

    // RV32M divide-family operation encodings. op[1] selects remainder and
    // op[0] selects unsigned.
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    // Divider control states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] SIGNED_MIN    = 32'h8000_0000;

endpackage

// File: rtl/rv32m_divider.sv
// rtl/rv32m_divider.sv - iterative radix-2 restoring DIV/DIVU/REM/REMU unit
//
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   in_valid / in_ready     request handshake; in_ready is high only in IDLE
//   op, rs1_val, rs2_val    operation and operands, sampled at accept only
//   rd_in                   destination index, carried to wb_addr
//   out_valid / out_ready   result handshake; result held stable in DONE
//   wb_data, wb_addr, wb_we register-file write port (wb_we = out_valid & out_ready)
module rv32m_divider
    import rv32m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_addr,
    output logic            wb_we
);

    logic [1:0]      state;
    logic [5:0]      cnt;
    logic            is_rem;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] dvd;   // dividend shifts out MSB-first, quotient shifts in at LSB
    logic [XLEN-1:0] rem;
    logic [4:0]      rd;

    // Operand decode at accept; magnitudes are only taken for signed ops
    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            overflow;

    assign is_signed = (op == OP_DIV) || (op == OP_REM);
    assign a_neg     = is_signed & rs1_val[XLEN-1];
    assign b_neg     = is_signed & rs2_val[XLEN-1];
    assign a_mag     = a_neg ? (~rs1_val + 1'b1) : rs1_val;
    assign b_mag     = b_neg ? (~rs2_val + 1'b1) : rs2_val;
    assign overflow  = is_signed && (rs1_val == SIGNED_MIN) && (rs2_val == DIV_BY_ZERO_Q);

    // Subtract-and-select step. The partial remainder before any shift is
    // below 2^31, so dropping rem[31] loses nothing; bit XLEN is the borrow.
    logic [XLEN:0]   diff;
    assign diff = {1'b0, rem[XLEN-2:0], dvd[XLEN-1]} - {1'b0, dvs};

    logic [XLEN-1:0] q_signed;
    logic [XLEN-1:0] r_signed;
    assign q_signed = neg_q ? (~dvd + 1'b1) : dvd;
    assign r_signed = neg_r ? (~rem + 1'b1) : rem;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign wb_we     = out_valid & out_ready;
    assign wb_addr   = rd;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            is_rem  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dvs     <= '0;
            dvd     <= '0;
            rem     <= '0;
            rd      <= '0;
            wb_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        is_rem <= op[1];
                        rd     <= rd_in;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        dvd    <= a_mag;
                        dvs    <= b_mag;
                        rem    <= '0;
                        cnt    <= '0;
                        if (rs2_val == '0) begin
                            wb_data <= op[1] ? rs1_val : DIV_BY_ZERO_Q;
                            state   <= ST_DONE;
                        end else if (overflow) begin
                            wb_data <= op[1] ? '0 : SIGNED_MIN;
                            state   <= ST_DONE;
                        end else begin
                            state   <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (!diff[XLEN]) begin
                        rem <= diff[XLEN-1:0];
                    end else begin
                        rem <= {rem[XLEN-2:0], dvd[XLEN-1]};
                    end
                    dvd <= {dvd[XLEN-2:0], ~diff[XLEN]};
                    if (cnt == 6'd31) begin
                        cnt   <= '0;
                        state <= ST_FIX;
                    end else begin
                        cnt   <= cnt + 6'd1;
                    end
                end
                ST_FIX: begin
                    wb_data <= is_rem ? r_signed : q_signed;
                    state   <= ST_DONE;
                end
                default: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32m_divider.sv
// tb/tb_rv32m_divider.sv - scoreboard bench for rv32m_divider
module tb_rv32m_divider;
    import rv32m_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [4:0]  rd_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic        wb_we;

    rv32m_divider #(.XLEN(32)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_data(wb_data), .wb_addr(wb_addr), .wb_we(wb_we)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        int          acc;
        int          lat;   // -1 means latency is not checked
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: each write strobe is the edge cyc+1 at which the register file writes
    always @(negedge clk) begin
        if (wb_we === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wb_we actual=0x%08h expected=none", wb_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_data", wb_data, e.data);
                chk("wb_addr", {27'd0, wb_addr}, {27'd0, e.addr});
                if (e.lat >= 0)
                    chk("latency", 32'(cyc + 1 - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int lat,
                         input bit push, output int acc);
        int n;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        op = o;
        rs1_val = a;
        rs2_val = b;
        rd_in = rd;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=0 expected=1");
        end
        acc = cyc + 1;
        if (push) begin
            e.data = exp; e.addr = rd; e.acc = acc; e.lat = lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 2'($urandom);
        rs1_val = $urandom;
        rs2_val = $urandom;
        rd_in = 5'($urandom);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || in_ready !== 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL %s_drain_timeout actual=%0d expected=0", name, sb.size());
            sb.delete();
        end
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int acc;
        int n;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
        resetn = 1'b1;

        // DIVU 100/7 with exact handshake timing around the write edge
        issue(OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 34, 1'b1, acc);
        n = 0;
        while (cyc + 1 < acc + 34 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t1_in_ready_done", {31'd0, in_ready}, 32'd0);
        chk("t1_wb_we_at_34", {31'd0, wb_we}, 32'd1);
        @(negedge clk);
        chk("t1_in_ready_at_35", {31'd0, in_ready}, 32'd1);
        chk("t1_wb_we_after", {31'd0, wb_we}, 32'd0);
        drain("t1");

        // Directed vectors: signed, unsigned, divide-by-zero, overflow
        vecs.push_back('{OP_DIV,  32'hFFFF_FFF9, 32'd2,        5'd1,  32'hFFFF_FFFD, 34});
        vecs.push_back('{OP_REM,  32'hFFFF_FFF9, 32'd2,        5'd2,  32'hFFFF_FFFF, 34});
        vecs.push_back('{OP_REMU, 32'hFFFF_FFFF, 32'd16,       5'd3,  32'd15,        34});
        vecs.push_back('{OP_DIV,  32'd7,         32'hFFFF_FFFE, 5'd4, 32'hFFFF_FFFD, 34});
        vecs.push_back('{OP_REM,  32'd7,         32'hFFFF_FFFE, 5'd6, 32'd1,         34});
        vecs.push_back('{OP_DIV,  32'h0000_1234, 32'd0,        5'd7,  32'hFFFF_FFFF, 1});
        vecs.push_back('{OP_DIVU, 32'h0000_1234, 32'd0,        5'd8,  32'hFFFF_FFFF, 1});
        vecs.push_back('{OP_REM,  32'h0000_1234, 32'd0,        5'd9,  32'h0000_1234, 1});
        vecs.push_back('{OP_REMU, 32'h0000_1234, 32'd0,        5'd10, 32'h0000_1234, 1});
        vecs.push_back('{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1});
        vecs.push_back('{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,        1});
        vecs.push_back('{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,        34});
        vecs.push_back('{OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 34});
        vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd0, 32'd1,         34});
        vecs.push_back('{OP_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd15, 32'hFFFF_FFFE, 34});
        foreach (vecs[i]) begin
            issue(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat, 1'b1, acc);
            drain("vec");
        end

        // Consumer stall: result held, no strobe, no new accept
        out_ready = 1'b0;
        issue(OP_DIVU, 32'd1000, 32'd10, 5'd17, 32'd100, -1, 1'b1, acc);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reach_done", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b1;
        op = OP_DIVU;
        rs1_val = 32'd50;
        rs2_val = 32'd5;
        rd_in = 5'd20;
        repeat (10) begin
            @(negedge clk);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_wb_data", wb_data, 32'd100);
            chk("stall_wb_we", {31'd0, wb_we}, 32'd0);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("stall");
        @(negedge clk);
        chk("stall_single_pulse", {31'd0, wb_we}, 32'd0);

        // Asynchronous reset during CALC after iteration 15
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd3, 5'd21, 32'd0, -1, 1'b0, acc);
        n = 0;
        while (cyc < acc + 16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_wb_we", {31'd0, wb_we}, 32'd0);
        chk("arst_wb_data", wb_data, 32'd0);
        chk("arst_wb_addr", {27'd0, wb_addr}, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        chk("arst_no_result", {31'd0, out_valid}, 32'd0);
        issue(OP_DIVU, 32'd9, 32'd3, 5'd7, 32'd3, 34, 1'b1, acc);
        drain("post_reset");

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover actual=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32m_divider.md
# rv32m_divider

Iterative RV32M divide/remainder unit that sits directly upstream of the integer register file. It accepts DIV/DIVU/REM/REMU operands read from rs1/rs2 and computes the result with a radix-2 restoring algorithm, one quotient bit per cycle. It presents the result, destination index and write strobe in the form the register file's write port consumes (data, index, enable). The core's control FSM stalls on `in_ready`/`out_valid`.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `op`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `rs1_val`  in  XLEN  dividend.
- `rs2_val`  in  XLEN  divisor.
- `rd_in`  in  5  destination index, carried through.
- `out_valid`  out  1  result held and stable.
- `out_ready`  in  1  consumer accepts result.
- `wb_data`  out  XLEN  result to register-file write data.
- `wb_addr`  out  5  destination index to register-file write address.
- `wb_we`  out  1  `out_valid & out_ready`, combinational; one-cycle write strobe.

## Operation
- **Accept.** A request is accepted on a rising edge with `in_valid & in_ready`. At that edge the unit registers `op` and `rd_in`, the operand signs, and the magnitudes of both operands. Magnitudes are taken only for the signed ops; a value of 0x80000000 has magnitude 0x80000000 as unsigned.
- **Special cases.** These are detected at accept and bypass the iteration:
  - Divisor 0: quotient 0xFFFFFFFF for both DIV and DIVU; remainder = `rs1_val` for both REM and REMU.
  - Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- **States.**
  - IDLE: `in_ready`=1. On accept, go to CALC, or to DONE for a special case.
  - CALC: 32 iterations with a 6-bit counter running 0..31. Each iteration forms {rem[30:0], dvd[31]} minus the divisor. If the difference is non-negative, the remainder takes the difference and the quotient bit is 1. Then `dvd` shifts left. After the count-31 iteration, go to FIX.
  - FIX: apply signs. A signed quotient is negated when the operand signs differ. A signed remainder takes the sign of the dividend. Select quotient or remainder by `op[1]`. Go to DONE.
  - DONE: `out_valid`=1 and `wb_data`/`wb_addr` are held stable. When `out_ready`=1 at an edge, go to IDLE.
- **Back-to-back.** No new request is accepted in DONE. Minimum issue interval is latency + 1 cycle.
- **x0 destination.** `rd_in`=0 is computed normally. Dropping the write is the register file's job.
- **Reset.** Assertion mid-operation aborts immediately to IDLE and discards the result. Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `wb_we`=0, `wb_data`=0, `wb_addr`=0, counter 0.

## Timing
- Accept at edge k, normal case: CALC occupies edges k+1..k+32, FIX is at k+33, and `out_valid` is high from k+34.
- Accept at edge k, special case: `out_valid` is high from k+1.
- `wb_we` rises in the same cycle `out_ready` is sampled high. The register file writes at that edge, which is also the edge that returns the unit to IDLE.
- `in_ready` rises in the cycle after the result is accepted.
- Operand inputs are sampled only at the accept edge and may change afterwards.
- `out_valid` never drops without `out_ready`, except on reset.

## Structure
- Shared package `rv32m_pkg`:
  - op encodings `OP_DIV`/`OP_DIVU`/`OP_REM`/`OP_REMU`.
  - state encoding IDLE/CALC/FIX/DONE.
  - constants `DIV_BY_ZERO_Q` = 0xFFFFFFFF and `SIGNED_MIN` = 0x80000000.
- Single module with no sub-module. The 33-bit subtract-and-select step is inline.

## Test plan
- DIVU 100 / 7, `rd_in`=5, `out_ready` tied high: `wb_data`=14, `wb_addr`=5, `wb_we` pulses exactly once at accept+34, `in_ready` high again at accept+35.
- DIV −7 / 2 → −3 (0xFFFFFFFD); REM −7 / 2 → −1 (0xFFFFFFFF); REMU 0xFFFFFFFF / 16 → 15; all with latency 34.
- Divide by zero, `rs1_val`=0x1234:
  - DIV/DIVU → 0xFFFFFFFF and REM/REMU → 0x1234.
  - All four have `out_valid` at accept+1.
- Overflow 0x80000000 / 0xFFFFFFFF:
  - DIV → 0x80000000 and REM → 0, both at accept+1.
  - DIVU → 0 through the normal 34-cycle path.
- `out_ready` held low for 10 cycles in DONE:
  - `out_valid` and `wb_data` stay stable, `wb_we`=0, and `in_ready`=0 while `in_valid` is asserted.
  - When `out_ready` rises, exactly one `wb_we` pulse occurs.
- `resetn` asserted asynchronously in the middle of CALC (iteration 15): all outputs are at reset values immediately. A new DIVU 9 / 3 issued after release returns 3 at the normal latency.
